tdc_calib_seq: RTL and testbench
================================

// Module: tdc_calib_seq
// PURPOSE
//  Sequences TDC startup and periodic online calibration. Gates the calibration ring oscillator, steers the TDC input mux to the
//  calibration source, and counts detection hits until the histogram has enough samples. It then hands off to the LUT builder
//  with a req/ack handshake and raises a done pulse. Sits beside tdc_hostif/tdc_ringosc; start/period/status are mapped to CSRs.
// PARAMETERS
//  g_SETTLE_CYCLES   1024      cycles oscillator runs before hits are counted (>=1)
//  g_HIT_COUNT       65536     hits to accumulate before LUT update (>=1, <2^g_HIT_WIDTH)
//  g_HIT_WIDTH       17        width of hit counter / hits_o
//  g_TIMEOUT_CYCLES  16777216  max cycles in ACCUM or UPDATE before error (>=1)
//  g_PERIOD_WIDTH    32        width of period_i / recalibration timer
// PORTS
//  sys_clk      in   1                system clock, all logic rising-edge
//  rst_n_i      in   1                asynchronous active-low reset
//  start_i      in   1                one-cycle start request (CSR write)
//  abort_i      in   1                one-cycle abort request
//  period_i     in   g_PERIOD_WIDTH   auto-recalibration interval in cycles; 0 = disabled
//  hit_i        in   1                one-cycle pulse per TDC detection
//  lut_ack_i    in   1                LUT builder finished (level or pulse)
//  osc_en_o     out  1                ring oscillator enable
//  calib_sel_o  out  1                1 = TDC input from calibration osc, 0 = signal_i
//  lut_req_o    out  1                LUT rebuild request, held until ack
//  busy_o       out  1                sequence in progress (state != IDLE)
//  done_o       out  1                one-cycle pulse on successful completion
//  err_o        out  1                sticky timeout flag, cleared by next accepted start
//  hits_o       out  g_HIT_WIDTH      hits counted in current/last run
// BEHAVIOUR
//  - Reset (async assert, sync deassert in use): state=IDLE, all outputs 0, timers 0.
//  - All outputs are registered; one cycle from state change to output change.
//  - States: IDLE -> SETTLE -> ACCUM -> UPDATE -> IDLE.
//  - IDLE: osc_en=0, calib_sel=0. Recal timer increments each cycle while period_i!=0.
//    Launch if start_i=1, or if timer==period_i-1 and period_i!=0. On launch: timer:=0, hits:=0, err:=0, go SETTLE.
//    start_i coincident with auto-launch gives a single launch. Timer resets to 0 whenever period_i==0 or a launch occurs.
//  - SETTLE: osc_en=1, calib_sel=1. Count g_SETTLE_CYCLES cycles, then go ACCUM. hit_i is ignored.
//  - ACCUM: osc_en=1, calib_sel=1. Each hit_i increments hits. When the count reaches g_HIT_COUNT, go UPDATE.
//    hits saturate at g_HIT_COUNT and never wrap. If g_TIMEOUT_CYCLES elapse first: err:=1, go IDLE, no done pulse.
//  - UPDATE: osc_en=0, calib_sel=1 (input held to calibration mux), lut_req=1. When lut_ack_i=1: lut_req:=0, done pulse, go IDLE.
//    Timeout also applies here: err:=1, lut_req dropped, go IDLE.
//  - start_i while busy is ignored; the recal timer does not run while busy.
//  - abort_i in any non-IDLE state: go IDLE next cycle, outputs drop to the IDLE values, no done, err unchanged.
//    abort_i outranks the other transitions when they occur in the same cycle. abort_i in IDLE has no effect.
//  - hits_o holds its last value in IDLE until the next launch.
//  - Timeout counter restarts on entry to ACCUM and on entry to UPDATE.
//  - Asserting rst_n_i mid-sequence returns everything to reset values asynchronously.
// TESTING
//  1. SETTLE=4, HIT=8. Pulse start_i, give 8 hits in ACCUM, ack 3 cycles after lut_req.
//     -> busy 1 cycle after start; osc_en high for SETTLE+ACCUM; done single pulse; hits_o=8; err=0.
//  2. TIMEOUT=100 with 3 hits only -> err_o=1 at cycle 100 of ACCUM, no lut_req, no done; next start clears err.
//  3. period_i=50, no start -> launches at IDLE cycle 50. Then set period_i=0 -> no further launches.
//  4. abort_i in ACCUM with hits=5, and abort_i in UPDATE -> IDLE next cycle, osc_en=0, calib_sel=0, lut_req=0, no done, hits_o=5.
//  5. start_i in the same cycle as auto-launch -> exactly one sequence; start_i pulse while busy -> ignored, one done only.
//  6. Drive hit_i continuously with HIT=8 -> hits_o stops at 8; rst_n_i low mid-ACCUM -> all outputs 0 immediately.

Source files
------------

// File: rtl/tdc_calib_seq.sv
// TDC calibration sequencer: settles the calibration ring oscillator, accumulates hits,
// then requests a LUT rebuild. Launches on a CSR start or on the auto-recalibration timer.
module tdc_calib_seq #(
    parameter int g_SETTLE_CYCLES  = 1024,
    parameter int g_HIT_COUNT      = 65536,
    parameter int g_HIT_WIDTH      = 17,
    parameter int g_TIMEOUT_CYCLES = 16777216,
    parameter int g_PERIOD_WIDTH   = 32
) (
    input  logic                      sys_clk,
    input  logic                      rst_n_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    input  logic [g_PERIOD_WIDTH-1:0] period_i,
    input  logic                      hit_i,
    input  logic                      lut_ack_i,
    output logic                      osc_en_o,
    output logic                      calib_sel_o,
    output logic                      lut_req_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [g_HIT_WIDTH-1:0]    hits_o
);

    // One phase counter serves both the settle delay and the ACCUM/UPDATE timeouts.
    localparam int CNT_MAX = (g_TIMEOUT_CYCLES > g_SETTLE_CYCLES) ? g_TIMEOUT_CYCLES : g_SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0]       SETTLE_LAST  = CNT_W'(g_SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       TIMEOUT_LAST = CNT_W'(g_TIMEOUT_CYCLES - 1);
    localparam logic [g_HIT_WIDTH-1:0] HIT_LAST     = g_HIT_WIDTH'(g_HIT_COUNT - 1);
    localparam logic [g_HIT_WIDTH-1:0] HIT_FULL     = g_HIT_WIDTH'(g_HIT_COUNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_ACCUM,
        S_UPDATE
    } state_t;

    state_t                    state, state_nx;
    logic [CNT_W-1:0]          cnt;
    logic [g_PERIOD_WIDTH-1:0] timer;
    logic                      auto_due;
    logic                      launch, timed_out, finished, count_hit;

    logic                   osc_en_nx, calib_sel_nx, lut_req_nx, busy_nx, done_nx, err_nx;
    logic [g_HIT_WIDTH-1:0] hits_nx;

    assign auto_due = (period_i != '0) && (timer == period_i - g_PERIOD_WIDTH'(1));

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its peers, independent of process evaluation order.
    always_ff @(posedge sys_clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            timer       <= '0;
            osc_en_o    <= 1'b0;
            calib_sel_o <= 1'b0;
            lut_req_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            hits_o      <= '0;
        end else begin
            state <= state_nx;
            cnt   <= (state == S_IDLE || state_nx != state) ? '0 : cnt + CNT_W'(1);
            if (state == S_IDLE)
                timer <= (launch || period_i == '0) ? '0 : timer + g_PERIOD_WIDTH'(1);
            osc_en_o    <= osc_en_nx;
            calib_sel_o <= calib_sel_nx;
            lut_req_o   <= lut_req_nx;
            busy_o      <= busy_nx;
            done_o      <= done_nx;
            err_o       <= err_nx;
            hits_o      <= hits_nx;
        end
    end

    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        launch    = 1'b0;
        timed_out = 1'b0;
        finished  = 1'b0;
        count_hit = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start_i || auto_due) begin
                    launch   = 1'b1;
                    state_nx = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort_i)                  state_nx = S_IDLE;
                else if (cnt == SETTLE_LAST)  state_nx = S_ACCUM;
            end
            S_ACCUM: begin
                if (abort_i) begin
                    state_nx = S_IDLE;
                end else begin
                    count_hit = hit_i && (hits_o != HIT_FULL);
                    if (count_hit && hits_o == HIT_LAST) begin
                        state_nx = S_UPDATE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        timed_out = 1'b1;
                        state_nx  = S_IDLE;
                    end
                end
            end
            S_UPDATE: begin
                if (abort_i) begin
                    state_nx = S_IDLE;
                end else if (lut_ack_i) begin
                    finished = 1'b1;
                    state_nx = S_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    timed_out = 1'b1;
                    state_nx  = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers line up with it.
    always_comb begin
        osc_en_nx    = (state_nx == S_SETTLE) || (state_nx == S_ACCUM);
        calib_sel_nx = (state_nx != S_IDLE);
        lut_req_nx   = (state_nx == S_UPDATE);
        busy_nx      = (state_nx != S_IDLE);
        done_nx      = finished;
        err_nx       = err_o;
        hits_nx      = hits_o;
        if (launch) begin
            err_nx  = 1'b0;
            hits_nx = '0;
        end else begin
            if (timed_out) err_nx  = 1'b1;
            if (count_hit) hits_nx = hits_o + g_HIT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_tdc_calib_seq.sv
// Bench for tdc_calib_seq: a phase/age reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_tdc_calib_seq;

    localparam int SETTLE  = 4;
    localparam int HITN    = 8;
    localparam int HW      = 5;
    localparam int TIMEOUT = 100;
    localparam int PW      = 8;

    localparam int P_IDLE = 0, P_SETTLE = 1, P_ACCUM = 2, P_UPDATE = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, abort = 1'b0, hit = 1'b0, lut_ack = 1'b0;
    logic [PW-1:0] period = '0;
    logic          osc_en_o, calib_sel_o, lut_req_o, busy_o, done_o, err_o;
    logic [HW-1:0] hits_o;

    int total = 0;
    int bad   = 0;

    tdc_calib_seq #(
        .g_SETTLE_CYCLES (SETTLE),
        .g_HIT_COUNT     (HITN),
        .g_HIT_WIDTH     (HW),
        .g_TIMEOUT_CYCLES(TIMEOUT),
        .g_PERIOD_WIDTH  (PW)
    ) dut (
        .sys_clk    (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .abort_i    (abort),
        .period_i   (period),
        .hit_i      (hit),
        .lut_ack_i  (lut_ack),
        .osc_en_o   (osc_en_o),
        .calib_sel_o(calib_sel_o),
        .lut_req_o  (lut_req_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .hits_o     (hits_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: which phase we are in and how long we have been there.
    int m_phase, m_age, m_idle_age, m_hits;
    bit m_err, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = P_IDLE; m_age = 0; m_idle_age = 0; m_hits = 0;
            m_err = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_phase)
                P_IDLE: begin
                    if (period == 0) m_idle_age = 0;
                    else             m_idle_age++;
                    if (start || (period != 0 && m_idle_age == int'(period))) begin
                        m_phase = P_SETTLE; m_age = 0; m_hits = 0; m_err = 0; m_idle_age = 0;
                    end
                end
                P_SETTLE: begin
                    m_age++;
                    if (abort)                m_phase = P_IDLE;
                    else if (m_age == SETTLE) begin m_phase = P_ACCUM; m_age = 0; end
                end
                P_ACCUM: begin
                    m_age++;
                    if (abort) m_phase = P_IDLE;
                    else begin
                        if (hit && m_hits < HITN) m_hits++;
                        if (m_hits == HITN)        begin m_phase = P_UPDATE; m_age = 0; end
                        else if (m_age == TIMEOUT) begin m_err = 1; m_phase = P_IDLE; end
                    end
                end
                default: begin
                    m_age++;
                    if (abort)                 m_phase = P_IDLE;
                    else if (lut_ack)          begin m_done = 1; m_phase = P_IDLE; end
                    else if (m_age == TIMEOUT) begin m_err = 1; m_phase = P_IDLE; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("osc_en",    32'(osc_en_o),    32'(m_phase == P_SETTLE || m_phase == P_ACCUM));
        check("calib_sel", 32'(calib_sel_o), 32'(m_phase != P_IDLE));
        check("lut_req",   32'(lut_req_o),   32'(m_phase == P_UPDATE));
        check("busy",      32'(busy_o),      32'(m_phase != P_IDLE));
        check("done",      32'(done_o),      32'(m_done));
        check("err",       32'(err_o),       32'(m_err));
        check("hits",      32'(hits_o),      32'(m_hits));
    end

    // Event counters observed at the clock edge.
    int done_cnt = 0, busy_rises = 0, lut_rises = 0;
    logic busy_prev = 1'b0, lut_prev = 1'b0;
    always @(posedge clk) begin
        if (done_o) done_cnt++;
        if (busy_o && !busy_prev) busy_rises++;
        if (lut_req_o && !lut_prev) lut_rises++;
        busy_prev = busy_o;
        lut_prev  = lut_req_o;
    end

    int d0, r0, l0;

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_osc",  32'(osc_en_o), 0);
        check("rst_hits", 32'(hits_o), 0);

        // 1: nominal run, ack three cycles after lut_req
        d0 = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        check("t1_busy", 32'(busy_o), 1);
        check("t1_osc",  32'(osc_en_o), 1);
        tick(4); hit = 1'b1; tick(8); hit = 1'b0;
        check("t1_lut_req", 32'(lut_req_o), 1);
        check("t1_osc_upd", 32'(osc_en_o), 0);
        check("t1_hits",    32'(hits_o), 8);
        tick(2); lut_ack = 1'b1; tick(1); lut_ack = 1'b0;
        check("t1_done", 32'(done_o), 1);
        tick(1);
        check("t1_done_drop", 32'(done_o), 0);
        check("t1_err",       32'(err_o), 0);
        tick(2);
        check("t1_done_count", 32'(done_cnt - d0), 1);

        // 2: timeout in ACCUM with only 3 hits
        d0 = done_cnt; l0 = lut_rises;
        start = 1'b1; tick(1); start = 1'b0;
        tick(4); hit = 1'b1; tick(3); hit = 1'b0;
        tick(96);
        check("t2_err_before", 32'(err_o), 0);
        check("t2_busy_before", 32'(busy_o), 1);
        tick(1);
        check("t2_err",  32'(err_o), 1);
        check("t2_busy", 32'(busy_o), 0);
        check("t2_hits", 32'(hits_o), 3);
        tick(2);
        check("t2_no_lut_req", 32'(lut_rises - l0), 0);
        check("t2_no_done",    32'(done_cnt - d0), 0);
        start = 1'b1; tick(1); start = 1'b0;
        check("t2_err_cleared", 32'(err_o), 0);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("t2_abort_settle", 32'(busy_o), 0);

        // 3: auto-recalibration at period 50, then disabled
        period = 8'd50;
        tick(49);
        check("t3_not_yet", 32'(busy_o), 0);
        tick(1);
        check("t3_launched", 32'(busy_o), 1);
        period = '0; abort = 1'b1; tick(1); abort = 1'b0;
        r0 = busy_rises;
        tick(120);
        check("t3_no_relaunch", 32'(busy_rises - r0), 0);

        // 4: abort in ACCUM at hits=5, then abort in UPDATE
        d0 = done_cnt;
        start = 1'b1; tick(1); start = 1'b0;
        tick(4); hit = 1'b1; tick(5); hit = 1'b0;
        abort = 1'b1; tick(1); abort = 1'b0;
        check("t4_busy",  32'(busy_o), 0);
        check("t4_osc",   32'(osc_en_o), 0);
        check("t4_calib", 32'(calib_sel_o), 0);
        check("t4_hits",  32'(hits_o), 5);
        start = 1'b1; tick(1); start = 1'b0;
        tick(4); hit = 1'b1; tick(8); hit = 1'b0;
        check("t4_in_update", 32'(lut_req_o), 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        check("t4_upd_lut_req", 32'(lut_req_o), 0);
        check("t4_upd_calib",   32'(calib_sel_o), 0);
        check("t4_upd_hits",    32'(hits_o), 8);
        tick(2);
        check("t4_no_done", 32'(done_cnt - d0), 0);

        // 5: start coincident with auto-launch, start while busy ignored
        d0 = done_cnt; r0 = busy_rises;
        period = 8'd20;
        tick(19); start = 1'b1; tick(1); start = 1'b0; period = '0;
        check("t5_busy", 32'(busy_o), 1);
        tick(1); start = 1'b1; tick(1); start = 1'b0;
        tick(2); hit = 1'b1; tick(8); hit = 1'b0;
        lut_ack = 1'b1; tick(1); lut_ack = 1'b0;
        check("t5_done", 32'(done_o), 1);
        tick(3);
        check("t5_one_launch", 32'(busy_rises - r0), 1);
        check("t5_one_done",   32'(done_cnt - d0), 1);

        // 6: continuous hits saturate, then async reset mid-ACCUM
        start = 1'b1; tick(1); start = 1'b0; hit = 1'b1;
        tick(12); tick(5);
        check("t6_hits_sat", 32'(hits_o), 8);
        check("t6_lut_req",  32'(lut_req_o), 1);
        abort = 1'b1; tick(1); abort = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        check("t6_hits_clear", 32'(hits_o), 0);
        tick(7);
        check("t6_hits_mid", 32'(hits_o), 3);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_osc",   32'(osc_en_o), 0);
        check("t6_rst_calib", 32'(calib_sel_o), 0);
        check("t6_rst_busy",  32'(busy_o), 0);
        check("t6_rst_hits",  32'(hits_o), 0);
        hit = 1'b0;
        tick(1); rst_n = 1'b1;
        tick(2);
        check("t6_after_rst", 32'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
